// File: rtl/msrv32_dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_dmem_bus_ctrl
//
// Purpose:
//   Data-memory bus controller for the msrv32 core. Takes the decoder's
//   memory controls, builds the byte-lane store mask and lane-replicated
//   store data, and runs a req/ready handshake with the data memory. The
//   pipeline is stalled from acceptance until the bus completes. Load data is
//   aligned to bit 0 and sign- or zero-extended before write-back.
//
//   Transaction flow: IDLE -> REQ -> DONE -> IDLE. The request is accepted in
//   IDLE. REQ holds every dm_* output stable until dm_ready_in is seen.
//   DONE raises one completion pulse for one cycle.
//
// Configuration:
//   MSRV32_DMEM_TIMEOUT_EN - when defined, a REQ that waits TIMEOUT_CYCLES
//   cycles without dm_ready_in is abandoned. DONE then pulses bus_err_out
//   instead of the normal completion pulse. When undefined, REQ waits
//   forever and bus_err_out is tied low.
//
// Ports:
//   ms_riscv32_mp_clk_in  in   1   clock, rising edge
//   ms_riscv32_mp_rst_in  in   1   synchronous active-high reset
//   mem_wr_req_in         in   1   store request
//   mem_rd_req_in         in   1   load request
//   load_size_in          in   2   00 byte, 01 half, 1x word
//   load_unsigned_in      in   1   1 = zero-extend load
//   misaligned_in         in   1   misaligned access flag (blocks acceptance)
//   trap_taken_in         in   1   trap this cycle (blocks acceptance)
//   addr_in               in   32  effective address
//   store_data_in         in   32  store data (rs2)
//   dm_req_out            out  1   bus request
//   dm_we_out             out  1   1 = write
//   dm_addr_out           out  32  word-aligned address
//   dm_wdata_out          out  32  lane-replicated store data
//   dm_wmask_out          out  4   byte enables, 0000 on reads
//   dm_ready_in           in   1   memory accepts/completes the request
//   dm_rdata_in           in   32  read data, valid with dm_ready_in
//   load_data_out         out  32  aligned, extended load result (held)
//   load_valid_out        out  1   load completion pulse
//   store_done_out        out  1   store completion pulse
//   stall_out             out  1   hold the pipeline
//   bus_err_out           out  1   timeout pulse
// ---------------------------------------------------------------------------
module msrv32_dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        mem_wr_req_in,
    input  logic        mem_rd_req_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic        misaligned_in,
    input  logic        trap_taken_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] store_data_in,
    output logic        dm_req_out,
    output logic        dm_we_out,
    output logic [31:0] dm_addr_out,
    output logic [31:0] dm_wdata_out,
    output logic [3:0]  dm_wmask_out,
    input  logic        dm_ready_in,
    input  logic [31:0] dm_rdata_in,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        store_done_out,
    output logic        stall_out,
    output logic        bus_err_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [29:0] addrWord_q, addrWord_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] loadData_q, loadData_d;

    logic        accept;
    logic        timeout;
    logic        errFlag;

    logic [3:0]  stMask;
    logic [31:0] stData;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] ldExt;

    // Store lane steering, computed from the live decoder inputs so it can
    // be captured on the acceptance edge. Bytes and halves are replicated
    // across the word so the memory picks them up on whichever lanes the
    // mask enables. Size 11 is treated as a word.
    always_comb begin
        stMask = 4'b1111;
        stData = store_data_in;
        case (load_size_in)
            2'b00: begin
                stMask = 4'b0001 << addr_in[1:0];
                stData = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                stMask = addr_in[1] ? 4'b1100 : 4'b0011;
                stData = {2{store_data_in[15:0]}};
            end
            default: begin
                stMask = 4'b1111;
                stData = store_data_in;
            end
        endcase
    end

    // Load alignment uses the lane and size captured at acceptance, because
    // the decoder inputs have moved on by the time read data returns.
    always_comb begin
        ldByte = dm_rdata_in[7:0];
        case (lane_q)
            2'd0:    ldByte = dm_rdata_in[7:0];
            2'd1:    ldByte = dm_rdata_in[15:8];
            2'd2:    ldByte = dm_rdata_in[23:16];
            default: ldByte = dm_rdata_in[31:24];
        endcase
        ldHalf = lane_q[1] ? dm_rdata_in[31:16] : dm_rdata_in[15:0];
        case (size_q)
            2'b00:   ldExt = {{24{~unsigned_q & ldByte[7]}}, ldByte};
            2'b01:   ldExt = {{16{~unsigned_q & ldHalf[15]}}, ldHalf};
            default: ldExt = dm_rdata_in;
        endcase
    end

    // Next-state logic for the transaction FSM and its captured request.
    // Everything captured at acceptance stays put through REQ, so the bus
    // sees stable signals however long the memory waits. A store beats a
    // load when both are requested together. A trap during REQ is
    // deliberately ignored, so a started transaction always finishes.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addrWord_d = addrWord_q;
        lane_d     = lane_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        loadData_d = loadData_q;
        accept     = 1'b0;

        case (state_q)
            IDLE: begin
                if ((mem_wr_req_in || mem_rd_req_in) && !misaligned_in && !trap_taken_in) begin
                    accept     = 1'b1;
                    state_d    = REQ;
                    we_d       = mem_wr_req_in;
                    addrWord_d = addr_in[31:2];
                    lane_d     = addr_in[1:0];
                    size_d     = load_size_in;
                    unsigned_d = load_unsigned_in;
                    wmask_d    = mem_wr_req_in ? stMask : 4'b0000;
                    wdata_d    = mem_wr_req_in ? stData : 32'd0;
                end
            end
            REQ: begin
                if (dm_ready_in) begin
                    state_d = DONE;
                    if (!we_q) begin
                        loadData_d = ldExt;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers. Reset abandons any transaction in flight
    // and clears every visible output, including the held load result.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            addrWord_q <= 30'd0;
            lane_q     <= 2'd0;
            size_q     <= 2'd0;
            unsigned_q <= 1'b0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
            loadData_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addrWord_q <= addrWord_d;
            lane_q     <= lane_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            loadData_q <= loadData_d;
        end
    end

`ifdef MSRV32_DMEM_TIMEOUT_EN
    localparam int unsigned CNT_RAW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W        = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam int unsigned TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmoCount_q, tmoCount_d;
    logic             busErr_q, busErr_d;

    // The counter holds the number of REQ cycles already spent. It expires
    // on the last permitted cycle if ready is still low. The error flag
    // stays set through DONE and is cleared by the next acceptance.
    assign timeout = (state_q == REQ) && !dm_ready_in
                     && (tmoCount_q == CNT_W'(TIMEOUT_LAST));

    always_comb begin
        tmoCount_d = tmoCount_q;
        busErr_d   = busErr_q;
        if (accept) begin
            tmoCount_d = '0;
            busErr_d   = 1'b0;
        end else if (state_q == REQ) begin
            tmoCount_d = tmoCount_q + CNT_W'(1);
        end
        if (timeout) begin
            busErr_d = 1'b1;
        end
    end

    // Timeout counter and error flag registers.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            tmoCount_q <= '0;
            busErr_q   <= 1'b0;
        end else begin
            tmoCount_q <= tmoCount_d;
            busErr_q   <= busErr_d;
        end
    end

    assign errFlag = busErr_q;
`else
    logic unusedTimeoutCfg;

    assign timeout          = 1'b0;
    assign errFlag          = 1'b0;
    assign unusedTimeoutCfg = |TIMEOUT_CYCLES;
`endif

    // The bus sees the captured request directly. Stall covers the
    // acceptance cycle combinationally and every REQ cycle. It drops in
    // DONE, when the completion pulse is raised.
    assign dm_req_out     = (state_q == REQ);
    assign dm_we_out      = we_q;
    assign dm_addr_out    = {addrWord_q, 2'b00};
    assign dm_wdata_out   = wdata_q;
    assign dm_wmask_out   = wmask_q;
    assign load_data_out  = loadData_q;
    assign stall_out      = accept | (state_q == REQ);
    assign load_valid_out = (state_q == DONE) & ~we_q & ~errFlag;
    assign store_done_out = (state_q == DONE) &  we_q & ~errFlag;
    assign bus_err_out    = (state_q == DONE) &  errFlag;

endmodule

// File: tb/tb_msrv32_dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msrv32_dmem_bus_ctrl
//
// Purpose:
//   Testbench for msrv32_dmem_bus_ctrl. It drives directed cases and random
//   transactions. For each accepted request, the expected bus view and the
//   expected completion are queued from a plain arithmetic model of
//   load/store lane behaviour. A monitor compares what the DUT presents.
//   The timeout case runs only when MSRV32_DMEM_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_msrv32_dmem_bus_ctrl;

   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        memWrReq, memRdReq, loadUnsigned, misaligned, trapTaken;
   logic [1:0]  loadSize;
   logic [31:0] addr, storeData;
   logic        dmReq, dmWe, dmReady;
   logic [31:0] dmAddr, dmWdata, dmRdata, loadData;
   logic [3:0]  dmWmask;
   logic        loadValid, storeDone, stall, busErr;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  mask;
   } busTxn_t;

   typedef struct {
      bit          isStore;
      bit          isErr;
      logic [31:0] data;
   } resp_t;

   busTxn_t     busQ[$];
   resp_t       respQ[$];
   int          total = 0;
   int          bad = 0;
   logic [31:0] lastLoad = 32'd0;

   msrv32_dmem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .mem_wr_req_in        (memWrReq),
      .mem_rd_req_in        (memRdReq),
      .load_size_in         (loadSize),
      .load_unsigned_in     (loadUnsigned),
      .misaligned_in        (misaligned),
      .trap_taken_in        (trapTaken),
      .addr_in              (addr),
      .store_data_in        (storeData),
      .dm_req_out           (dmReq),
      .dm_we_out            (dmWe),
      .dm_addr_out          (dmAddr),
      .dm_wdata_out         (dmWdata),
      .dm_wmask_out         (dmWmask),
      .dm_ready_in          (dmReady),
      .dm_rdata_in          (dmRdata),
      .load_data_out        (loadData),
      .load_valid_out       (loadValid),
      .store_done_out       (storeDone),
      .stall_out            (stall),
      .bus_err_out          (busErr)
   );

   // Free-running clock.
   always #HALF clk = ~clk;

   // One comparison: bumps the counters and reports a mismatch.
   function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference model: store byte enables for an access size and byte offset.
   function automatic logic [3:0] modelMask(input logic [1:0] size, input logic [1:0] a);
      if (size == 2'b00) return 4'(1 << a);
      if (size == 2'b01) return 4'(3 << (a & 2'b10));
      return 4'hF;
   endfunction

   // Reference model: store data copied into every lane of its size.
   function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] d);
      if (size == 2'b00) return (d & 32'hFF) * 32'h01010101;
      if (size == 2'b01) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   // Reference model: pick the addressed byte or half, then extend it.
   function automatic logic [31:0] modelLoad(input logic [31:0] rd, input logic [1:0] size,
                                             input logic [1:0] a, input bit uns);
      logic [31:0] v;
      if (size == 2'b00) begin
         v = (rd >> (8 * a)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFFFF00;
      end else if (size == 2'b01) begin
         v = (rd >> (16 * 32'(a[1]))) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF0000;
      end else begin
         v = rd;
      end
      return v;
   endfunction

   // Monitor: samples away from the clock edge, after the driver has moved
   // the inputs. Each bus cycle is compared against the head of the bus
   // queue, and each completion pulse against the head of the response
   // queue. The held load result is compared every cycle.
   initial begin
      busTxn_t b;
      resp_t   r;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (dmReq) begin
               if (busQ.size() == 0) begin
                  checkOutput("bus_unexpected", 32'(dmReq), 32'd0);
               end else begin
                  b = busQ[0];
                  checkOutput("bus_we", 32'(dmWe), 32'(b.we));
                  checkOutput("bus_addr", dmAddr, b.addr);
                  checkOutput("bus_mask", 32'(dmWmask), 32'(b.mask));
                  if (b.we) checkOutput("bus_wdata", dmWdata, b.wdata);
                  if (dmReady) void'(busQ.pop_front());
               end
            end
            if (loadValid || storeDone || busErr) begin
               if (respQ.size() == 0) begin
                  checkOutput("resp_unexpected", 32'({busErr, loadValid, storeDone}), 32'd0);
               end else begin
                  r = respQ.pop_front();
                  checkOutput("resp_pulses", 32'({busErr, loadValid, storeDone}),
                              32'({r.isErr, !r.isStore && !r.isErr, r.isStore && !r.isErr}));
                  if (!r.isStore && !r.isErr) lastLoad = r.data;
               end
            end
            checkOutput("load_data", loadData, lastLoad);
         end
      end
   end

   // Runs one request from IDLE through to the cycle after DONE.
   // waits = number of REQ cycles with ready low before ready goes high.
   task automatic applyStimulus(input bit wr, input bit rd, input logic [1:0] size, input bit uns,
                                input bit mis, input bit trap, input logic [31:0] a,
                                input logic [31:0] d, input int waits, input logic [31:0] rdata,
                                input bit trapInReq);
      bit      acc;
      busTxn_t b;
      resp_t   r;
      acc = (wr || rd) && !mis && !trap;
      @(negedge clk);
      memWrReq = wr; memRdReq = rd; loadSize = size; loadUnsigned = uns;
      misaligned = mis; trapTaken = trap; addr = a; storeData = d;
      dmReady = 1'($urandom % 2); dmRdata = rdata;
      if (acc) begin
         b.we = wr; b.addr = a & 32'hFFFF_FFFC;
         b.mask = wr ? modelMask(size, a[1:0]) : 4'b0000;
         b.wdata = modelWdata(size, d);
         busQ.push_back(b);
         r.isStore = wr; r.isErr = 1'b0;
         r.data = wr ? 32'd0 : modelLoad(rdata, size, a[1:0], uns);
         respQ.push_back(r);
      end
      #2;
      checkOutput("idle_noreq", 32'(dmReq), 32'd0);
      checkOutput("stall_accept", 32'(stall), 32'(acc));
      @(negedge clk);
      memWrReq = 1'b0; memRdReq = 1'b0; misaligned = 1'b0; trapTaken = trapInReq;
      dmReady = 1'b0;
      if (!acc) begin
         #2;
         checkOutput("ignored_noreq", 32'(dmReq), 32'd0);
         checkOutput("ignored_stall", 32'(stall), 32'd0);
         trapTaken = 1'b0;
         return;
      end
      for (int i = 0; i <= waits; i++) begin
         if (i > 0) @(negedge clk);
         dmReady = (i == waits);
         #2;
         checkOutput("req_active", 32'(dmReq), 32'd1);
         checkOutput("req_stall", 32'(stall), 32'd1);
      end
      @(negedge clk);
      dmReady = 1'b0; trapTaken = 1'b0; misaligned = 1'b0;
      memWrReq = 1'b1;
      #2;
      checkOutput("done_stall", 32'(stall), 32'd0);
      checkOutput("done_pulse", 32'(wr ? storeDone : loadValid), 32'd1);
      @(negedge clk);
      memWrReq = 1'b0;
   endtask

   // Reset arriving while a read waits in REQ abandons the transaction.
   task automatic resetMidReq();
      busTxn_t b;
      @(negedge clk);
      memRdReq = 1'b1; loadSize = 2'b10; loadUnsigned = 1'b0; addr = 32'h0000_0400;
      dmReady = 1'b0;
      b.we = 1'b0; b.addr = 32'h0000_0400; b.mask = 4'b0000; b.wdata = 32'd0;
      busQ.push_back(b);
      @(negedge clk);
      memRdReq = 1'b0;
      #2;
      checkOutput("rst_pre_req", 32'(dmReq), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      busQ.delete();
      respQ.delete();
      lastLoad = 32'd0;
      #2;
      checkOutput("rst_req_drop", 32'(dmReq), 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      checkOutput("rst_addr", dmAddr, 32'd0);
   endtask

`ifdef MSRV32_DMEM_TIMEOUT_EN
   // Ready never rises: after four REQ cycles the bus is dropped and
   // bus_err_out pulses in place of load_valid_out.
   task automatic timeoutCase();
      busTxn_t b;
      resp_t   r;
      @(negedge clk);
      memRdReq = 1'b1; loadSize = 2'b10; loadUnsigned = 1'b0; addr = 32'h0000_0300;
      dmReady = 1'b0;
      b.we = 1'b0; b.addr = 32'h0000_0300; b.mask = 4'b0000; b.wdata = 32'd0;
      busQ.push_back(b);
      r.isStore = 1'b0; r.isErr = 1'b1; r.data = 32'd0;
      respQ.push_back(r);
      @(negedge clk);
      memRdReq = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         #2;
         checkOutput("tmo_req", 32'(dmReq), 32'd1);
      end
      @(negedge clk);
      if (busQ.size() > 0) void'(busQ.pop_front());
      #2;
      checkOutput("tmo_drop", 32'(dmReq), 32'd0);
      checkOutput("tmo_stall", 32'(stall), 32'd0);
      checkOutput("tmo_err", 32'(busErr), 32'd1);
      @(negedge clk);
   endtask
`endif

   // Main sequence: reset checks, directed cases, reset mid-transaction,
   // and randomized traffic.
   initial begin
      rst = 1'b1;
      memWrReq = 1'b0; memRdReq = 1'b0; loadSize = 2'b00; loadUnsigned = 1'b0;
      misaligned = 1'b0; trapTaken = 1'b0; addr = 32'd0; storeData = 32'd0;
      dmReady = 1'b0; dmRdata = 32'd0;
      repeat (2) @(negedge clk);
      #2;
      checkOutput("rst_req", 32'(dmReq), 32'd0);
      checkOutput("rst_we", 32'(dmWe), 32'd0);
      checkOutput("rst_dm_addr", dmAddr, 32'd0);
      checkOutput("rst_wdata", dmWdata, 32'd0);
      checkOutput("rst_wmask", 32'(dmWmask), 32'd0);
      checkOutput("rst_load_data", loadData, 32'd0);
      checkOutput("rst_pulses", 32'({loadValid, storeDone, busErr}), 32'd0);
      checkOutput("rst_stall_out", 32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // sw, sb, lh, lhu, lb, lw with wait states, misaligned, trap, both requests, size 11
      applyStimulus(1, 0, 2'b10, 0, 0, 0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'd0, 0);
      applyStimulus(1, 0, 2'b00, 0, 0, 0, 32'h0000_0103, 32'h0000_00A5, 0, 32'd0, 0);
      applyStimulus(0, 1, 2'b01, 0, 0, 0, 32'h0000_0202, 32'd0, 0, 32'h8001_1234, 0);
      applyStimulus(0, 1, 2'b01, 1, 0, 0, 32'h0000_0202, 32'd0, 1, 32'h8001_5678, 0);
      applyStimulus(0, 1, 2'b00, 0, 0, 0, 32'h0000_0101, 32'd0, 0, 32'h0000_7F00, 0);
      applyStimulus(0, 1, 2'b10, 0, 0, 0, 32'h0000_0204, 32'd0, 2, 32'hCAFE_F00D, 0);
      applyStimulus(1, 0, 2'b10, 0, 1, 0, 32'h0000_0101, 32'h1234_5678, 0, 32'd0, 0);
      applyStimulus(0, 1, 2'b10, 0, 0, 1, 32'h0000_0100, 32'd0, 0, 32'h1111_2222, 0);
      applyStimulus(1, 1, 2'b01, 0, 0, 0, 32'h0000_0302, 32'h0000_BEEF, 1, 32'h5555_AAAA, 1);
      applyStimulus(0, 1, 2'b11, 0, 0, 0, 32'h0000_0308, 32'd0, 0, 32'h89AB_CDEF, 0);

      resetMidReq();

      for (int n = 0; n < 80; n++) begin
         applyStimulus(1'($urandom % 2), 1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                       ($urandom % 6) == 0, ($urandom % 6) == 0, $urandom, $urandom,
                       int'($urandom % 4), $urandom, 1'($urandom % 2));
      end

`ifdef MSRV32_DMEM_TIMEOUT_EN
      timeoutCase();
`endif

      repeat (3) @(negedge clk);
      #2;
      checkOutput("busq_drained", 32'(busQ.size()), 32'd0);
      checkOutput("respq_drained", 32'(respQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
